// File: rtl/db_pkg.sv
// Shared definitions for the switch-bounce emulator: FSM state type,
// LFSR geometry (16-bit Fibonacci, x^16+x^14+x^13+x^11+1), default seed,
// the idle glitch trigger pattern and a one-step LFSR helper.
package db_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        BOUNCE = 1'b1
    } state_t;

    localparam int          LFSR_W         = 16;
    // Feedback taps as a bit mask: bits 15, 13, 12, 10 (x^16, x^14, x^13, x^11).
    localparam logic [15:0] LFSR_TAPS      = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED   = 16'hACE1;
    localparam logic [7:0]  GLITCH_PATTERN = 8'hA5;

    // One Fibonacci step: shift left, parity of the tapped bits enters at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
        return {q[LFSR_W-2:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR. Loads 'seed' while reset is high and
// advances on every clock otherwise. A non-zero seed keeps it off the
// all-zero lock-up state forever (maximal-length polynomial).
module lfsr16
    import db_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    // Seed on reset, step the shift register every cycle otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= seed;
        end else begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/sw_bounce_gen.sv
// Mechanical switch emulator. When the clean target 'cmd' changes, 'sw'
// bounces randomly (one LFSR bit resampled every DWELL cycles) for
// BOUNCE_CYCLES cycles, then settles at the target and pulses 'done'.
//
// Interface: 'cmd' is a level, sampled synchronously on every rising edge
// (no synchronizer inside). There is no valid/ready handshake: a change of
// 'cmd' is the request, 'busy' marks the window, 'done' is a one-cycle
// completion pulse that is never high together with 'busy'.
//
// Optional feature: define SW_BOUNCE_GEN_GLITCH_EN to add single-cycle idle
// glitches (sw = !tgt for one cycle whenever lfsr[7:0] == 8'hA5 in IDLE).
module sw_bounce_gen
    import db_pkg::*;
#(
    parameter int unsigned BOUNCE_CYCLES = 20,
    parameter int unsigned DWELL         = 2,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic clk,
    input  logic reset,
    input  logic cmd,
    output logic sw,
    output logic busy,
    output logic done,
    output logic state_dbg
);

    localparam logic [15:0] SEED_EFF     = (SEED == 16'h0000) ? DEFAULT_SEED : SEED;
    localparam logic [15:0] CNT_RELOAD   = 16'(BOUNCE_CYCLES - 1);
    localparam logic [7:0]  DWELL_RELOAD = 8'(DWELL - 1);

    state_t      state_q, state_d;
    logic        tgt_q, tgt_d;
    logic        sw_q, sw_d;
    logic        done_q, done_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  dwell_q, dwell_d;
    logic [15:0] lfsr_q;
    logic        glitch;
    logic        lfsr_unused;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (SEED_EFF),
        .q     (lfsr_q)
    );

`ifdef SW_BOUNCE_GEN_GLITCH_EN
    assign glitch = (lfsr_q[7:0] == GLITCH_PATTERN);
`else
    assign glitch = 1'b0;
`endif

    // Only a few LFSR bits drive behaviour; the rest are deliberately ignored.
    assign lfsr_unused = ^lfsr_q;

    // State and datapath registers; reset clears everything.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tgt_q   <= 1'b0;
            sw_q    <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= 16'd0;
            dwell_q <= 8'd0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            sw_q    <= sw_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            dwell_q <= dwell_d;
        end
    end

    // Next-state logic: start/restart the window on a target change, bounce
    // sw on dwell expiry, settle and pulse done when the window count ends.
    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        sw_d    = sw_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        dwell_d = dwell_q;
        case (state_q)
            IDLE: begin
                if (cmd != tgt_q) begin
                    tgt_d   = cmd;
                    cnt_d   = CNT_RELOAD;
                    dwell_d = DWELL_RELOAD;
                    sw_d    = tgt_q;
                    state_d = BOUNCE;
                end else begin
                    sw_d = tgt_q ^ glitch;
                end
            end
            BOUNCE: begin
                if (cmd != tgt_q) begin
                    // Target moved mid-window: restart the whole window.
                    tgt_d   = cmd;
                    cnt_d   = CNT_RELOAD;
                    dwell_d = DWELL_RELOAD;
                end else if (cnt_q == 16'd0) begin
                    sw_d    = tgt_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                    if (dwell_q == 8'd0) begin
                        sw_d    = lfsr_q[0];
                        dwell_d = DWELL_RELOAD;
                    end else begin
                        dwell_d = dwell_q - 8'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sw        = sw_q;
    assign busy      = (state_q == BOUNCE);
    assign done      = done_q;
    assign state_dbg = (state_q == BOUNCE);

endmodule

// File: tb/tb_sw_bounce_gen.sv
// Testbench for sw_bounce_gen: a reset/startup vector table, hand-written
// restart and mid-window reset sequences, and a randomized run, all checked
// against a window-age reference model of the switch behaviour.
module tb_sw_bounce_gen;

    localparam int          BC       = 20;
    localparam int          DW       = 2;
    localparam logic [15:0] SEED_EXP = 16'hACE1;
`ifdef SW_BOUNCE_GEN_GLITCH_EN
    localparam bit GLITCH_ON = 1'b1;
`else
    localparam bit GLITCH_ON = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cmd = 1'b0;
    logic sw, busy, done, state_dbg;

    always #5 clk = ~clk;

    sw_bounce_gen #(
        .BOUNCE_CYCLES (BC),
        .DWELL         (DW),
        .SEED          (16'hACE1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd       (cmd),
        .sw        (sw),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Window described by its age (cycles since the last start/restart):
    // sw resamples lfsr bit 0 whenever age mod DWELL hits DWELL-1, and the
    // window ends on age BOUNCE_CYCLES-1.
    logic        m_busy = 1'b0;
    logic        m_tgt  = 1'b0;
    logic        m_sw   = 1'b0;
    logic        m_done = 1'b0;
    int          m_age  = 0;
    logic [15:0] m_lfsr = SEED_EXP;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        int   taps[4];
        logic fb;
        taps = '{16, 14, 13, 11};
        fb = 1'b0;
        for (int i = 0; i < 4; i++) fb ^= s[taps[i]-1];
        return {s[14:0], fb};
    endfunction

    function automatic logic glitch_term(input logic [15:0] s);
        return GLITCH_ON && (s[7:0] == 8'hA5);
    endfunction

    task automatic model_step();
        logic [15:0] cur;
        cur    = m_lfsr;
        m_done = 1'b0;
        if (reset) begin
            m_busy = 1'b0;
            m_tgt  = 1'b0;
            m_sw   = 1'b0;
            m_age  = 0;
            m_lfsr = SEED_EXP;
            return;
        end
        if (cmd != m_tgt) begin
            if (!m_busy) m_sw = m_tgt;
            m_tgt  = cmd;
            m_busy = 1'b1;
            m_age  = 0;
        end else if (!m_busy) begin
            m_sw = m_tgt ^ glitch_term(cur);
        end else if (m_age == BC - 1) begin
            m_sw   = m_tgt;
            m_done = 1'b1;
            m_busy = 1'b0;
        end else begin
            if ((m_age % DW) == DW - 1) m_sw = cur[0];
            m_age++;
        end
        m_lfsr = lfsr_step(cur);
    endtask

    // ---------------- driver ----------------
    // Drive inputs (from a negedge), clock once, then compare at the negedge.
    task automatic tick(input logic r, input logic c);
        reset = r;
        cmd   = c;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("model_sw", {15'd0, sw}, {15'd0, m_sw});
        check("model_busy", {15'd0, busy}, {15'd0, m_busy});
        check("model_done", {15'd0, done}, {15'd0, m_done});
        check("done_busy_excl", {15'd0, done & busy}, 16'd0);
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic rst;
        logic cmd;
        logic chk_sw;
        logic exp_sw;
        logic exp_busy;
        logic exp_done;
    } vec_t;

    vec_t vecs[24];

    int first_done;
    int done_cnt;

    initial begin
        // Reset one cycle, cmd rises, 20-cycle window, settle with done.
        vecs[0] = '{rst: 1'b1, cmd: 1'b0, chk_sw: 1'b1, exp_sw: 1'b0, exp_busy: 1'b0, exp_done: 1'b0};
        vecs[1] = '{rst: 1'b0, cmd: 1'b0, chk_sw: 1'b1, exp_sw: 1'b0, exp_busy: 1'b0, exp_done: 1'b0};
        for (int i = 2; i <= 21; i++)
            vecs[i] = '{rst: 1'b0, cmd: 1'b1, chk_sw: (i <= 3), exp_sw: 1'b0, exp_busy: 1'b1, exp_done: 1'b0};
        vecs[22] = '{rst: 1'b0, cmd: 1'b1, chk_sw: 1'b1, exp_sw: 1'b1, exp_busy: 1'b0, exp_done: 1'b1};
        vecs[23] = '{rst: 1'b0, cmd: 1'b1, chk_sw: 1'b1, exp_sw: 1'b1, exp_busy: 1'b0, exp_done: 1'b0};

        @(negedge clk);
        for (int i = 0; i < 24; i++) begin
            tick(vecs[i].rst, vecs[i].cmd);
            if (vecs[i].chk_sw) check($sformatf("tbl_sw[%0d]", i), {15'd0, sw}, {15'd0, vecs[i].exp_sw});
            check($sformatf("tbl_busy[%0d]", i), {15'd0, busy}, {15'd0, vecs[i].exp_busy});
            check($sformatf("tbl_done[%0d]", i), {15'd0, done}, {15'd0, vecs[i].exp_done});
        end

        // Falling target: identical window, single done, then long settle at 0.
        first_done = 0;
        done_cnt   = 0;
        for (int i = 1; i <= 321; i++) begin
            tick(1'b0, 1'b0);
            if (done) begin
                done_cnt++;
                if (first_done == 0) first_done = i;
            end
        end
        check("fall_first_done", 16'(first_done), 16'd21);
        check("fall_done_count", 16'(done_cnt), 16'd1);
        check("fall_settled_sw", {15'd0, sw}, 16'd0);

        // Restart: cmd back to 0 at window cycle 10, done only 21 ticks later.
        done_cnt = 0;
        for (int i = 1; i <= 10; i++) begin
            tick(1'b0, 1'b1);
            if (done) done_cnt++;
        end
        first_done = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(1'b0, 1'b0);
            if (done) begin
                done_cnt++;
                if (first_done == 0) first_done = i;
            end
        end
        check("restart_first_done", 16'(first_done), 16'd21);
        check("restart_done_count", 16'(done_cnt), 16'd1);
        check("restart_sw", {15'd0, sw}, 16'd0);

        // Reset mid-window: abort, lfsr reseeded, fresh window afterwards.
        done_cnt = 0;
        for (int i = 1; i <= 5; i++) begin
            tick(1'b0, 1'b1);
            if (done) done_cnt++;
        end
        tick(1'b1, 1'b1);
        check("rst_mid_sw", {15'd0, sw}, 16'd0);
        check("rst_mid_busy", {15'd0, busy}, 16'd0);
        check("rst_mid_lfsr", dut.u_lfsr.q, SEED_EXP);
        first_done = 0;
        for (int i = 1; i <= 30; i++) begin
            tick(1'b0, 1'b1);
            if (done) begin
                done_cnt++;
                if (first_done == 0) first_done = i;
            end
        end
        check("rst_mid_fresh_done", 16'(first_done), 16'd21);
        check("rst_mid_done_count", 16'(done_cnt), 16'd1);

        // Randomized cmd changes with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            logic r, c;
            c = cmd;
            if ($urandom_range(0, 29) == 0) c = ~cmd;
            r = ($urandom_range(0, 499) == 0);
            tick(r, c);
        end

`ifdef SW_BOUNCE_GEN_GLITCH_EN
        // Long idle at 0 so every lfsr[7:0]==A5 occurrence shows as a glitch.
        tick(1'b1, 1'b0);
        for (int i = 0; i < 70000; i++) tick(1'b0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
